// File: rtl/dc_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dc_buffer_pkg
// Shared constants and helpers for the buffer controller slice:
//   DEFAULT_DEPTH - default number of storage slots
//   MAX_DEPTH     - widest pointer the helpers are sized for
//   occ_width()   - width of an occupancy count for a given depth
//   rotl1()       - rotate a one-hot vector of a given width left by one
// ---------------------------------------------------------------------------
package dc_buffer_pkg;

   localparam int DEFAULT_DEPTH = 8;
   localparam int MAX_DEPTH     = 1024;

   // The count must reach BUFFER_DEPTH-1, and one extra bit keeps the
   // comparisons against the capacity free of wrap concerns.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Rotate the low `width` bits of v left by one, MSB wrapping to bit 0.
   // Bits at or above `width` are assumed zero and are cleared in the result.
   function automatic logic [MAX_DEPTH-1:0] rotl1(input logic [MAX_DEPTH-1:0] v,
                                                 input int                    width);
      logic [MAX_DEPTH-1:0] mask;
      mask = {MAX_DEPTH{1'b1}} >> (MAX_DEPTH - width);
      return ((v << 1) | (v >> (width - 1))) & mask;
   endfunction

endpackage

// File: rtl/dc_onehot_ptr.sv
// ---------------------------------------------------------------------------
// dc_onehot_ptr
// Rotating one-hot slot pointer with synchronous clear.
// Ports:
//   clk     in   clock, rising edge
//   rstn    in   synchronous active-low reset, returns pointer to slot 0
//   clr     in   synchronous clear to slot 0, wins over advance
//   advance in   rotate the pointer left by one slot
//   ptr     out  one-hot slot select (WIDTH bits)
// ---------------------------------------------------------------------------
module dc_onehot_ptr
   import dc_buffer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             advance,
   output logic [WIDTH-1:0] ptr
);

   localparam logic [WIDTH-1:0] SLOT0 = WIDTH'(1);

   logic [WIDTH-1:0] ptr_q;
   logic [WIDTH-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = SLOT0;
      end else if (advance) begin
         ptr_d = WIDTH'(rotl1(MAX_DEPTH'(ptr_q), WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= SLOT0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/dc_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// dc_buffer_ctrl
// Pointer/occupancy controller for an externally held storage array that is
// written every cycle at write_pointer. Because that write is unconditional,
// write_pointer must always address a free slot, so one slot is sacrificed and
// the usable capacity is BUFFER_DEPTH-1.
// Ports:
//   clk           in   clock, rising edge
//   rstn          in   synchronous active-low reset (wins over flush)
//   flush         in   synchronous clear of pointers and occupancy
//   in_valid      in   producer offers a word
//   in_ready      out  word accepted this cycle (registered-state decode)
//   out_valid     out  read port holds the oldest word (registered-state decode)
//   out_ready     in   consumer takes the word
//   write_pointer out  one-hot storage write slot
//   read_pointer  out  one-hot storage read slot
//   occupancy     out  number of stored words
//   almost_full   out  registered occupancy >= AFULL_LEVEL
// ---------------------------------------------------------------------------
module dc_buffer_ctrl
   import dc_buffer_pkg::*;
#(
   parameter int BUFFER_DEPTH = DEFAULT_DEPTH,
   parameter int AFULL_LEVEL  = 6
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                flush,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [BUFFER_DEPTH-1:0]             write_pointer,
   output logic [BUFFER_DEPTH-1:0]             read_pointer,
   output logic [occ_width(BUFFER_DEPTH)-1:0]  occupancy,
   output logic                                almost_full
);

   localparam int              OCC_W = occ_width(BUFFER_DEPTH);
   localparam logic [OCC_W-1:0] CAP  = OCC_W'(BUFFER_DEPTH - 1);
   localparam logic [OCC_W-1:0] AFL  = OCC_W'(AFULL_LEVEL);

   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             afull_q;
   logic             afull_d;
   logic             push;
   logic             pop;

   // Handshake flags come only from the occupancy register, so neither
   // in_ready nor out_valid has a path from any input.
   assign in_ready  = (occ_q < CAP);
   assign out_valid = (occ_q != '0);

   assign push = in_valid  & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
      // Compare the next count so the flag changes on the same edge as occupancy.
      afull_d = (occ_d >= AFL);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         occ_q   <= '0;
         afull_q <= 1'b0;
      end else begin
         occ_q   <= occ_d;
         afull_q <= afull_d;
      end
   end

   dc_onehot_ptr #(.WIDTH(BUFFER_DEPTH)) u_wr_ptr (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (flush),
      .advance (push),
      .ptr     (write_pointer)
   );

   dc_onehot_ptr #(.WIDTH(BUFFER_DEPTH)) u_rd_ptr (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (flush),
      .advance (pop),
      .ptr     (read_pointer)
   );

   assign occupancy   = occ_q;
   assign almost_full = afull_q;

endmodule

// File: doc/dc_buffer_ctrl.md
DC_BUFFER_CTRL -- requirements
Module: dc_buffer_ctrl

Interface
REQ-001 Parameter BUFFER_DEPTH, default 8: number of storage slots; legal range 2..1024.
REQ-002 Parameter AFULL_LEVEL, default 6: almost_full threshold; legal range 1..BUFFER_DEPTH-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all pointer and occupancy state.
REQ-006 in_valid  input  1  producer presents a word for the storage array.
REQ-007 in_ready  output  1  controller accepts the word this cycle.
REQ-008 out_valid  output  1  storage read port holds the oldest valid word.
REQ-009 out_ready  input  1  consumer takes the word this cycle.
REQ-010 write_pointer  output  BUFFER_DEPTH  one-hot slot select for the storage write port.
REQ-011 read_pointer  output  BUFFER_DEPTH  one-hot slot select for the storage read port.
REQ-012 occupancy  output  clog2(BUFFER_DEPTH)+1  number of stored words.
REQ-013 almost_full  output  1  occupancy >= AFULL_LEVEL.

Function
REQ-014 The storage array writes every cycle at write_pointer. write_pointer SHALL therefore always select a free slot, so usable capacity is CAP = BUFFER_DEPTH-1.
REQ-015 Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
REQ-016 in_ready SHALL equal (occupancy < CAP), decoded from registered state only, with no combinational path from any input.
REQ-017 out_valid SHALL equal (occupancy != 0), decoded from registered state only, with no combinational path from any input.
REQ-018 On push, write_pointer SHALL rotate left by one position, with the MSB wrapping to the LSB.
REQ-019 On pop, read_pointer SHALL rotate left by one position, with the MSB wrapping to the LSB.
REQ-020 Occupancy update rules:
- push only: +1
- pop only: -1
- push and pop in the same cycle: unchanged, and both pointers advance.
REQ-021 Latency: a word pushed at edge t SHALL be presented with out_valid=1 from cycle t+1. There is no fall-through.
REQ-022 Full boundary: at occupancy == CAP, in_ready=0. A same-cycle pop SHALL raise in_ready in the next cycle, not combinationally.
REQ-023 Empty boundary: at occupancy == 0, out_valid=0 and out_ready is ignored.
REQ-024 write_pointer SHALL never equal read_pointer unless occupancy == 0.
REQ-025 flush has priority over push and pop. In a flush cycle:
- any handshake that cycle is discarded
- both pointers return to slot 0 (value 1)
- occupancy returns to 0.
REQ-026 Each pointer SHALL hold exactly one set bit at all times after reset.
REQ-027 almost_full SHALL be registered and updated in the same cycle as occupancy.

Reset
REQ-028 While rstn=0 at a clock edge, all state SHALL take these values on that edge:
- write_pointer = 1
- read_pointer = 1
- occupancy = 0
- almost_full = 0
- in_ready = 1
- out_valid = 0
REQ-029 Reset asserted mid-operation SHALL discard stored words exactly as flush does. rstn has priority over flush.

Structure
REQ-030 The package dc_buffer_pkg SHALL hold the default depth constant, the clog2 width helper, and the one-hot rotate function.
REQ-031 One sub-module, dc_onehot_ptr, SHALL be instantiated twice:
- ports: clk, rstn, clr, advance, ptr
- function: a rotating one-hot register with synchronous clear.
REQ-032 The occupancy counter and flag logic SHALL reside in dc_buffer_ctrl.

Verification
REQ-033 Reset then idle: rstn low for 2 cycles, then high, with in_valid=0 -> write_pointer=8'h01, read_pointer=8'h01, occupancy=0, in_ready=1, out_valid=0.
REQ-034 Fill to full: 7 consecutive pushes with out_ready=0 ->
- write_pointer steps 02,04,...,80
- occupancy=7, in_ready=0, almost_full=1 from occupancy 6
- an 8th in_valid is not accepted.
REQ-035 Wrap-around: from full, 7 pops -> read_pointer steps to 8'h80, occupancy=0. Then 1 push -> write_pointer wraps 8'h80 -> 8'h01.
REQ-036 Simultaneous push and pop at occupancy 3, for 20 cycles -> occupancy stays 3 and both pointers advance once per cycle.
REQ-037 Flush with in_valid=1 and out_ready=1 at occupancy 5 -> next cycle: pointers=8'h01, occupancy=0, out_valid=0, and no word was accepted.
REQ-038 Random traffic (10k cycles) against a queue model -> pointers always one-hot, write_pointer != read_pointer when occupancy > 0, and data order preserved.
